cacheline_mem_arbiter: RTL and testbench
========================================

// Module: cacheline_mem_arbiter
// PURPOSE
// - Shares one 256-bit physical-memory port between the I-cache and D-cache miss/writeback ports.
// - Sits between the two caches and main memory (pmem) in the pipelined RV32I core.
// - Grants one requester at a time and latches its address and write data.
// - Routes pmem_resp back to the granted requester only.
// - Fixed D-priority with an I starvation guard, or round-robin; chosen by parameter.
// PARAMETERS
// ROUND_ROBIN   0   1: alternate on contention; 0: D-cache wins contention
// STARVE_LIMIT  4   fixed-priority mode only: max consecutive D grants while I waits (>=1)
// PORTS
// clk            in   1    clock, all state on rising edge
// rst_n          in   1    asynchronous active-low reset
// i_pmem_read    in   1    I-cache line read request, level, held until i_pmem_resp
// i_pmem_address in   32   I-cache line address (offset bits [4:0] = 0)
// i_pmem_rdata   out  256  line data (= pmem_rdata)
// i_pmem_resp    out  1    I transaction done
// d_pmem_read    in   1    D-cache line read request, level
// d_pmem_write   in   1    D-cache line writeback request, level
// d_pmem_address in   32   D-cache line address
// d_pmem_wdata   in   256  D-cache writeback line
// d_pmem_rdata   out  256  line data (= pmem_rdata)
// d_pmem_resp    out  1    D transaction done
// pmem_read      out  1    memory read strobe
// pmem_write     out  1    memory write strobe
// pmem_address   out  32   latched address
// pmem_wdata     out  256  latched write line
// pmem_rdata     in   256  memory read line, valid with pmem_resp
// pmem_resp      in   1    memory done, 1-cycle pulse
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   state=IDLE; pmem_read, pmem_write, i/d_pmem_resp = 0; pmem_address = 0; pmem_wdata = 0.
//   starve_cnt = 0; last_grant = I.
//   A transaction in flight is abandoned; no resp is issued for it.
// - States: IDLE, SERVE_I, SERVE_D.
// - IDLE, request pending at edge t:
//   - Pick the winner.
//   - Latch its address; latch d_pmem_wdata if D is writing.
//   - Enter SERVE_x.
//   - pmem_read/pmem_write assert from cycle t+1.
//   - Arbitration latency is 1 cycle.
// - Winner selection:
//   - Only I requests: I. Only D requests: D.
//   - Both request, ROUND_ROBIN=1: requester != last_grant.
//   - Both request, ROUND_ROBIN=0: D, unless starve_cnt==STARVE_LIMIT, then I.
// - starve_cnt (fixed-priority mode):
//   - +1 on each D grant while I is requesting; saturates.
//   - Cleared on every I grant.
// - D request with both read and write high is illegal; it is treated as a write.
// - SERVE_x:
//   - pmem_read = latched read strobe; pmem_write = latched write strobe.
//   - Strobes held steady until pmem_resp.
//   - Requester inputs are ignored after the grant edge; latched copies drive pmem.
// - On pmem_resp in SERVE_x:
//   - x_pmem_resp=1 in the same cycle (combinational); the other requester's resp stays 0.
//   - Next state IDLE; strobes drop next cycle; last_grant = x.
//   - i/d_pmem_rdata = pmem_rdata at all times; meaningful only with own resp.
// - Requesters deassert in the cycle after resp. IDLE samples requests at that edge, so a
//   served request is never re-granted. Min gap between memory transactions: 1 idle cycle.
// - pmem_resp in IDLE is ignored: no resp is forwarded and no state changes.
// - pmem_address and pmem_wdata hold their last latched values in IDLE.
// TESTING
// - I read, addr 0x0000_1040:
//   pmem_read=1 at t+1 with addr 0x1040; mem resp after 5 cycles;
//   i_pmem_resp pulses 1 cycle with rdata; d_pmem_resp stays 0.
// - D write, addr 0x0000_2000, wdata=0xA5 repeated:
//   pmem_write=1, pmem_wdata=A5..; changing d_pmem_wdata mid-transaction does not alter pmem_wdata.
// - ROUND_ROBIN=0, STARVE_LIMIT=2, I and D held continuously (D re-requests after every resp):
//   grant order D,D,I,D,D,I.
// - ROUND_ROBIN=1, both held continuously from reset:
//   grant order D,I,D,I (last_grant resets to I).
// - rst_n low for 1 cycle mid SERVE_D:
//   strobes 0 immediately (async); no d_pmem_resp; next request is granted cleanly.
// - Spurious pmem_resp in IDLE: no resp to either cache.
// - D read and write both high: pmem_write=1, pmem_read=0.

Source files
------------

// File: rtl/cacheline_mem_arbiter.sv
// cacheline_mem_arbiter: shares one 256-bit physical-memory port between the
// I-cache and D-cache. One requester is granted at a time. Its address and
// write line are latched at the grant edge. The memory response goes back
// only to the granted requester.
module cacheline_mem_arbiter #(
    parameter int ROUND_ROBIN  = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    // I-cache port
    input  logic         i_pmem_read,
    input  logic [31:0]  i_pmem_address,
    output logic [255:0] i_pmem_rdata,
    output logic         i_pmem_resp,
    // D-cache port
    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [31:0]  d_pmem_address,
    input  logic [255:0] d_pmem_wdata,
    output logic [255:0] d_pmem_rdata,
    output logic         d_pmem_resp,
    // physical memory port
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;

    state_e          state_q, state_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [31:0]     addr_q, addr_d;
    logic [255:0]    wdata_q, wdata_d;
    logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            last_grant_d_q, last_grant_d_d;  // 1: last grant went to D
    logic            d_req;
    logic            pick_d;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rd_q           <= 1'b0;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            starve_cnt_q   <= '0;
            last_grant_d_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_q           <= rd_d;
            wr_q           <= wr_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            starve_cnt_q   <= starve_cnt_d;
            last_grant_d_q <= last_grant_d_d;
        end
    end

    // Arbitration, latching and response routing.
    always_comb begin
        state_d        = state_q;
        rd_d           = rd_q;
        wr_d           = wr_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        starve_cnt_d   = starve_cnt_q;
        last_grant_d_d = last_grant_d_q;
        i_pmem_resp    = 1'b0;
        d_pmem_resp    = 1'b0;
        pick_d         = 1'b0;
        d_req          = d_pmem_read | d_pmem_write;

        case (state_q)
            IDLE: begin
                if (i_pmem_read || d_req) begin
                    if (!i_pmem_read)
                        pick_d = 1'b1;
                    else if (!d_req)
                        pick_d = 1'b0;
                    else if (ROUND_ROBIN != 0)
                        pick_d = !last_grant_d_q;
                    else
                        pick_d = (starve_cnt_q != STARVE_MAX);

                    if (pick_d) begin
                        state_d = SERVE_D;
                        addr_d  = d_pmem_address;
                        // read+write together is treated as a write
                        wr_d    = d_pmem_write;
                        rd_d    = d_pmem_read & ~d_pmem_write;
                        if (d_pmem_write)
                            wdata_d = d_pmem_wdata;
                        if (ROUND_ROBIN == 0 && i_pmem_read && starve_cnt_q != STARVE_MAX)
                            starve_cnt_d = starve_cnt_q + 1'b1;
                    end else begin
                        state_d      = SERVE_I;
                        addr_d       = i_pmem_address;
                        rd_d         = 1'b1;
                        wr_d         = 1'b0;
                        starve_cnt_d = '0;
                    end
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    i_pmem_resp    = 1'b1;
                    state_d        = IDLE;
                    rd_d           = 1'b0;
                    wr_d           = 1'b0;
                    last_grant_d_d = 1'b0;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    d_pmem_resp    = 1'b1;
                    state_d        = IDLE;
                    rd_d           = 1'b0;
                    wr_d           = 1'b0;
                    last_grant_d_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Bench for cacheline_mem_arbiter: a table of single-transaction vectors on a
// fixed-priority instance, plus sequences for reset, spurious response,
// starvation and round-robin ordering.
module tb_cacheline_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance A: fixed priority, STARVE_LIMIT=2
    logic         a_i_rd, a_d_rd, a_d_wr, a_i_resp, a_d_resp;
    logic [31:0]  a_ia, a_da, a_paddr;
    logic [255:0] a_dwd, a_i_rdata, a_d_rdata, a_pwdata, a_prdata;
    logic         a_prd, a_pwr, a_presp;
    // instance B: round robin
    logic         b_i_rd, b_d_rd, b_d_wr, b_i_resp, b_d_resp;
    logic [31:0]  b_ia, b_da, b_paddr;
    logic [255:0] b_dwd, b_i_rdata, b_d_rdata, b_pwdata, b_prdata;
    logic         b_prd, b_pwr, b_presp;

    cacheline_mem_arbiter #(.ROUND_ROBIN(0), .STARVE_LIMIT(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_read(a_i_rd), .i_pmem_address(a_ia), .i_pmem_rdata(a_i_rdata), .i_pmem_resp(a_i_resp),
        .d_pmem_read(a_d_rd), .d_pmem_write(a_d_wr), .d_pmem_address(a_da), .d_pmem_wdata(a_dwd),
        .d_pmem_rdata(a_d_rdata), .d_pmem_resp(a_d_resp),
        .pmem_read(a_prd), .pmem_write(a_pwr), .pmem_address(a_paddr), .pmem_wdata(a_pwdata),
        .pmem_rdata(a_prdata), .pmem_resp(a_presp)
    );

    cacheline_mem_arbiter #(.ROUND_ROBIN(1), .STARVE_LIMIT(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_read(b_i_rd), .i_pmem_address(b_ia), .i_pmem_rdata(b_i_rdata), .i_pmem_resp(b_i_resp),
        .d_pmem_read(b_d_rd), .d_pmem_write(b_d_wr), .d_pmem_address(b_da), .d_pmem_wdata(b_dwd),
        .d_pmem_rdata(b_d_rdata), .d_pmem_resp(b_d_resp),
        .pmem_read(b_prd), .pmem_write(b_pwr), .pmem_address(b_paddr), .pmem_wdata(b_pwdata),
        .pmem_rdata(b_prdata), .pmem_resp(b_presp)
    );

    typedef struct {
        logic         i_rd, d_rd, d_wr;
        logic [31:0]  ia, da;
        logic [255:0] dwd;
        logic         exp_rd, exp_wr;
        logic [31:0]  exp_addr;
        logic [255:0] exp_wdata;
        logic         exp_grant_d;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] PA5 = {32{8'hA5}};
    localparam logic [255:0] P5A = {32{8'h5A}};
    localparam logic [255:0] P3C = {32{8'h3C}};
    localparam logic [255:0] PC3 = {32{8'hC3}};
    localparam logic [31:0]  I_ADDR = 32'h0000_1040;
    localparam logic [31:0]  D_ADDR = 32'h0000_2000;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int k, input logic ir, input logic dr, input logic dw,
                           input logic [31:0] ia, input logic [31:0] da, input logic [255:0] dwd,
                           input logic er, input logic ew, input logic [31:0] eaddr,
                           input logic [255:0] ewd, input logic egd);
        vecs[k].i_rd = ir;  vecs[k].d_rd = dr;  vecs[k].d_wr = dw;
        vecs[k].ia = ia;    vecs[k].da = da;    vecs[k].dwd = dwd;
        vecs[k].exp_rd = er; vecs[k].exp_wr = ew; vecs[k].exp_addr = eaddr;
        vecs[k].exp_wdata = ewd; vecs[k].exp_grant_d = egd;
    endtask

    // One full transaction on instance A driven from IDLE.
    task automatic run_vec(input int k);
        logic [255:0] rdat;
        @(negedge clk);
        a_i_rd = vecs[k].i_rd; a_d_rd = vecs[k].d_rd; a_d_wr = vecs[k].d_wr;
        a_ia = vecs[k].ia; a_da = vecs[k].da; a_dwd = vecs[k].dwd;
        @(negedge clk);
        check($sformatf("v%0d_strobes", k), {a_prd, a_pwr}, {vecs[k].exp_rd, vecs[k].exp_wr});
        check($sformatf("v%0d_addr", k), a_paddr, vecs[k].exp_addr);
        check($sformatf("v%0d_wdata", k), a_pwdata, vecs[k].exp_wdata);
        // requester inputs change while served; latched copies must hold
        a_ia = 32'hFFFF_FFE0; a_da = 32'hEEEE_EEE0; a_dwd = '1;
        @(negedge clk);
        @(negedge clk);
        check($sformatf("v%0d_strobes_held", k), {a_prd, a_pwr}, {vecs[k].exp_rd, vecs[k].exp_wr});
        check($sformatf("v%0d_addr_held", k), a_paddr, vecs[k].exp_addr);
        check($sformatf("v%0d_wdata_held", k), a_pwdata, vecs[k].exp_wdata);
        rdat = {8{32'hDEAD_0000 | 32'(k)}};
        a_prdata = rdat; a_presp = 1'b1;
        #1;
        check($sformatf("v%0d_i_resp", k), a_i_resp, !vecs[k].exp_grant_d);
        check($sformatf("v%0d_d_resp", k), a_d_resp, vecs[k].exp_grant_d);
        check($sformatf("v%0d_rdata", k), vecs[k].exp_grant_d ? a_d_rdata : a_i_rdata, rdat);
        @(negedge clk);
        a_presp = 1'b0; a_i_rd = 1'b0; a_d_rd = 1'b0; a_d_wr = 1'b0;
        check($sformatf("v%0d_strobes_drop", k), {a_prd, a_pwr}, 2'b00);
        @(negedge clk);
        check($sformatf("v%0d_no_regrant", k), {a_prd, a_pwr}, 2'b00);
    endtask

    // Requests are already held high; record n grants and compare order.
    task automatic run_grants(input bit use_b, input int n, input logic [5:0] exp_d, input string tag);
        bit ok;
        logic got_d;
        for (int k = 0; k < n; k++) begin
            ok = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (use_b ? (b_prd | b_pwr) : (a_prd | a_pwr)) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                check($sformatf("%s_timeout_%0d", tag, k), 1'b0, 1'b1);
                return;
            end
            got_d = ((use_b ? b_paddr : a_paddr) == D_ADDR);
            check($sformatf("%s_grant_%0d", tag, k), got_d, exp_d[k]);
            @(negedge clk);
            @(negedge clk);
            if (use_b) b_presp = 1'b1; else a_presp = 1'b1;
            @(negedge clk);
            b_presp = 1'b0; a_presp = 1'b0;
        end
    endtask

    initial begin
        //      k  ir  dr  dw  ia            da            dwd  er  ew  eaddr         ewd  egd
        set_vec(0, 1, 0, 0, 32'h0000_1040, 32'h0,        '0,  1, 0, 32'h0000_1040, '0,  0);
        set_vec(1, 0, 0, 1, 32'h0,        32'h0000_2000, PA5, 0, 1, 32'h0000_2000, PA5, 1);
        set_vec(2, 0, 1, 0, 32'h0,        32'h0000_3000, P5A, 1, 0, 32'h0000_3000, PA5, 1);
        set_vec(3, 0, 1, 1, 32'h0,        32'h0000_4000, P5A, 0, 1, 32'h0000_4000, P5A, 1);
        set_vec(4, 1, 1, 0, 32'h0000_1080, 32'h0000_5000, PC3, 1, 0, 32'h0000_5000, P5A, 1);
        set_vec(5, 1, 0, 1, 32'h0000_10C0, 32'h0000_6000, P3C, 0, 1, 32'h0000_6000, P3C, 1);
        set_vec(6, 1, 1, 0, 32'h0000_1100, 32'h0000_7000, PA5, 1, 0, 32'h0000_1100, P3C, 0);
        set_vec(7, 1, 1, 0, 32'h0000_1140, 32'h0000_8000, PA5, 1, 0, 32'h0000_8000, P3C, 1);
        set_vec(8, 1, 0, 0, 32'h0000_1180, 32'h0,        PA5, 1, 0, 32'h0000_1180, P3C, 0);
        set_vec(9, 1, 0, 1, 32'h0000_11C0, 32'h0000_A000, PC3, 0, 1, 32'h0000_A000, PC3, 1);

        rst_n = 1'b0;
        a_i_rd = 0; a_d_rd = 0; a_d_wr = 0; a_ia = '0; a_da = '0; a_dwd = '0; a_prdata = '0; a_presp = 0;
        b_i_rd = 0; b_d_rd = 0; b_d_wr = 0; b_ia = '0; b_da = '0; b_dwd = '0; b_prdata = '0; b_presp = 0;
        @(negedge clk);
        @(negedge clk);
        check("reset_strobes", {a_prd, a_pwr, b_prd, b_pwr}, 4'b0000);
        check("reset_addr", a_paddr, 32'h0);
        check("reset_wdata", a_pwdata, 256'h0);
        check("reset_resp", {a_i_resp, a_d_resp}, 2'b00);
        rst_n = 1'b1;

        for (int k = 0; k < NV; k++)
            run_vec(k);

        // spurious memory response while idle
        @(negedge clk);
        a_presp = 1'b1;
        #1;
        check("spurious_resp", {a_i_resp, a_d_resp}, 2'b00);
        @(negedge clk);
        a_presp = 1'b0;
        check("spurious_strobes", {a_prd, a_pwr}, 2'b00);
        check("spurious_addr_hold", a_paddr, 32'h0000_A000);
        check("spurious_wdata_hold", a_pwdata, PC3);

        // reset in the middle of a D writeback
        a_d_wr = 1'b1; a_da = 32'h0000_9000; a_dwd = PA5;
        @(negedge clk);
        check("rst_mid_write_granted", a_pwr, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; a_d_wr = 1'b0; a_presp = 1'b1;
        #1;
        check("rst_mid_strobes", {a_prd, a_pwr}, 2'b00);
        check("rst_mid_addr", a_paddr, 32'h0);
        check("rst_mid_no_resp", {a_i_resp, a_d_resp}, 2'b00);
        @(negedge clk);
        a_presp = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("rst_after_idle", {a_prd, a_pwr}, 2'b00);
        a_i_rd = 1'b1; a_ia = I_ADDR;
        @(negedge clk);
        check("rst_regrant_strobes", {a_prd, a_pwr}, 2'b10);
        check("rst_regrant_addr", a_paddr, I_ADDR);
        repeat (4) @(negedge clk);
        a_prdata = {8{32'h1234_5678}}; a_presp = 1'b1;
        #1;
        check("rst_regrant_resp", {a_i_resp, a_d_resp}, 2'b10);
        check("rst_regrant_rdata", a_i_rdata, {8{32'h1234_5678}});
        @(negedge clk);
        a_presp = 1'b0; a_i_rd = 1'b0;
        @(negedge clk);

        // starvation guard: both held, starve count is 0 after the I grant above
        a_i_rd = 1'b1; a_ia = I_ADDR; a_d_rd = 1'b1; a_da = D_ADDR;
        run_grants(1'b0, 6, 6'b011011, "fixed");
        a_i_rd = 1'b0; a_d_rd = 1'b0;

        // round robin from reset: last grant starts at I
        b_i_rd = 1'b1; b_ia = I_ADDR; b_d_rd = 1'b1; b_da = D_ADDR;
        run_grants(1'b1, 4, 6'b000101, "rr");
        b_i_rd = 1'b0; b_d_rd = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
